// File: rtl/bpred_pkg.sv
// rtl/bpred_pkg.sv - shared widths, byte-enables and update-queue entry for the predictor update path
package bpred_pkg;

   localparam int BIMODAL_IDX_W = 8;
   localparam int BIMODAL_CNT_W = 2;
   localparam int BIMODAL_W     = 12;
   localparam int CARRY_W       = 9;
   localparam int BTB_W         = 30;

   localparam logic [3:0] BE_BIMODAL_ONLY = 4'b0001;
   localparam logic [3:0] BE_FULL         = 4'b1111;

   typedef struct packed {
      logic [31:0]          pc4;
      logic [31:0]          target;
      logic                 taken;
      logic                 miss;
      logic [BIMODAL_W-1:0] bimodal;
      logic [CARRY_W-1:0]   carry;
   } bpred_upd_t;

   // A taken branch with the right direction still misses if the BTB target was stale.
   function automatic logic is_miss(input logic p_dir, input logic taken,
                                    input logic [31:0] p_target, input logic [31:0] target);
      return (p_dir != taken) || (taken && (p_target != target));
   endfunction

endpackage

// File: rtl/bpred_upd_fifo.sv
// rtl/bpred_upd_fifo.sv - synchronous FIFO of predictor update entries with full/empty/count
module bpred_upd_fifo
   import bpred_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_push,
   input  bpred_upd_t               i_push_data,
   input  logic                     i_pop,
   output bpred_upd_t               o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   bpred_upd_t    r_mem [DEPTH];

   logic w_push;
   logic w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   // DEPTH is a power of two, so pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/bpred_update_ctrl.sv
// rtl/bpred_update_ctrl.sv - resolves branch outcome, issues mispredict redirect, queues predictor updates
module bpred_update_ctrl
   import bpred_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     ex_valid,
   output logic                     ex_ready,
   input  logic [31:0]              ex_pc4,
   input  logic                     ex_taken,
   input  logic [31:0]              ex_target,
   input  logic                     ex_p_dir,
   input  logic [31:0]              ex_p_target,
   input  logic [BIMODAL_W-1:0]     ex_bimodal,
   input  logic [CARRY_W-1:0]       ex_carry,
   input  logic                     soin_bpredictor_stall,
   output logic                     execute_bpredictor_update,
   output logic [31:0]              execute_bpredictor_PC4,
   output logic [31:0]              execute_bpredictor_target,
   output logic                     execute_bpredictor_dir,
   output logic                     execute_bpredictor_miss,
   output logic [BIMODAL_W-1:0]     execute_bpredictor_bimodal,
   output logic [BTB_W-1:0]         up_btb_data,
   output logic [CARRY_W-1:0]       up_carry_data,
   output logic [3:0]               byte_en,
   output logic                     redirect_valid,
   output logic [31:0]              redirect_pc,
   output logic [$clog2(QDEPTH):0]  queue_count
);

   logic        w_accept;
   logic        w_miss;
   logic        w_full;
   logic        w_empty;
   logic        w_pop;
   bpred_upd_t  w_entry;
   bpred_upd_t  w_head;
   bpred_upd_t  w_head_vis;

   logic        r_redirect_valid;
   logic [31:0] r_redirect_pc;

   assign ex_ready = !w_full;
   assign w_accept = ex_valid && ex_ready;
   assign w_miss   = is_miss(ex_p_dir, ex_taken, ex_p_target, ex_target);
   assign w_pop    = !w_empty && !soin_bpredictor_stall;

   // Not-taken entries store the fall-through PC so the BTB data is always defined.
   always_comb begin
      w_entry         = '0;
      w_entry.pc4     = ex_pc4;
      w_entry.target  = ex_taken ? ex_target : ex_pc4;
      w_entry.taken   = ex_taken;
      w_entry.miss    = w_miss;
      w_entry.bimodal = ex_bimodal;
      w_entry.carry   = ex_carry;
   end

   bpred_upd_fifo #(.DEPTH(QDEPTH)) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_push      (w_accept),
      .i_push_data (w_entry),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (queue_count)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_redirect_valid <= w_accept && w_miss;
         if (w_accept && w_miss) r_redirect_pc <= ex_taken ? ex_target : ex_pc4;
      end
   end

   // An empty queue presents all-zero head fields, which also covers the reset state.
   assign w_head_vis = w_empty ? '0 : w_head;

   assign execute_bpredictor_update  = !w_empty;
   assign execute_bpredictor_PC4     = w_head_vis.pc4;
   assign execute_bpredictor_target  = w_head_vis.target;
   assign execute_bpredictor_dir     = w_head_vis.taken;
   assign execute_bpredictor_miss    = w_head_vis.miss;
   assign execute_bpredictor_bimodal = w_head_vis.bimodal;
   assign up_btb_data                = w_head_vis.target[31:2];
   assign up_carry_data              = w_head_vis.carry;
   assign byte_en                    = w_empty ? 4'b0000 :
                                       (w_head_vis.taken ? BE_FULL : BE_BIMODAL_ONLY);

   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;

endmodule
